// File: rtl/or4_arb_pkg.sv
// or4_arb_pkg: shared types and constants for the four-way round-robin arbiter
package or4_arb_pkg;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: first masked request at or after ptr, scanning upward mod 4
module rr_pick4
    import or4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  off;
    assign cand  = req & mask;
    // rot[i] holds cand[(i+ptr) mod 4], so bit 0 is the highest priority
    assign rot   = N_REQ'({cand, cand} >> ptr);
    assign valid = |cand;
    assign off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : rot[3] ? 2'd3 : 2'd0;
    assign idx   = off + ptr;
endmodule

// File: rtl/or4_rr_arbiter.sv
// or4_rr_arbiter: round-robin arbiter for four requesters with bounded hold time
module or4_rr_arbiter
    import or4_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic             any_req,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy
);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    state_t           state, state_nx;
    logic [ID_W-1:0]  ptr, ptr_nx, grant_id_nx, pick_idx;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
    logic [N_REQ-1:0] grant_nx, mask;
    logic             pick_valid, own_req, at_max, take;
    assign any_req = |req;
    assign own_req = req[grant_id];
    assign at_max  = hold_cnt == CNT_W'(HOLD_MAX);
    // the current owner is never a candidate, so a pick while busy is always a hand-over
    assign mask    = state == GRANT ? ~grant : '1;
    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .mask  (mask),
        .valid (pick_valid),
        .idx   (pick_idx)
    );
    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        grant_id_nx = grant_id;
        hold_cnt_nx = hold_cnt;
        ptr_nx      = ptr;
        take        = pick_valid && (state == IDLE || !own_req || at_max);
        if (take) begin
            state_nx    = GRANT;
            grant_nx    = N_REQ'(1) << pick_idx;
            grant_id_nx = pick_idx;
            hold_cnt_nx = CNT_W'(1);
            ptr_nx      = pick_idx + ID_W'(1);
        end else if (state == GRANT && !own_req) begin
            state_nx    = IDLE;
            grant_nx    = '0;
            hold_cnt_nx = '0;
        end else if (state == GRANT && !at_max) begin
            hold_cnt_nx = hold_cnt + CNT_W'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            grant_id <= grant_id_nx;
            busy     <= |grant_nx;
            hold_cnt <= hold_cnt_nx;
            ptr      <= ptr_nx;
        end
    end
endmodule

// File: tb/tb_or4_rr_arbiter.sv
// tb_or4_rr_arbiter: directed and random checks against a behavioural round-robin model
module tb_or4_rr_arbiter;
    localparam int HOLD_MAX = 8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b1111;
    logic       any_req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    int         errors = 0;
    int         checks = 0;
    int         m_own = -1;
    int         m_cnt = 0;
    int         m_ptr = 0;

    or4_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .any_req  (any_req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p, input int excl);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [3:0] r);
        int nxt;
        nxt = -1;
        if (m_own < 0) nxt = pick(r, m_ptr, -1);
        else if (!r[m_own] || m_cnt == HOLD_MAX) nxt = pick(r, m_ptr, m_own);
        if (nxt >= 0) begin
            m_own = nxt;
            m_cnt = 1;
            m_ptr = (nxt + 1) % 4;
        end else if (m_own >= 0 && !r[m_own]) begin
            m_own = -1;
            m_cnt = 0;
        end else if (m_own >= 0 && m_cnt < HOLD_MAX) begin
            m_cnt++;
        end
    endtask

    task automatic check_all();
        check("grant", int'(grant), m_own < 0 ? 0 : (1 << m_own));
        check("busy", int'(busy), m_own >= 0 ? 1 : 0);
        if (m_own >= 0) check("grant_id", int'(grant_id), m_own);
        check("any_req", int'(any_req), req != 0 ? 1 : 0);
        check("hold_cnt", int'(dut.hold_cnt), m_cnt);
        check("ptr", int'(dut.ptr), m_ptr);
    endtask

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_edge(req);
        #1;
        check_all();
    endtask

    task automatic do_reset(input logic [3:0] r);
        req = r;
        rst_n = 1'b0;
        m_own = -1;
        m_cnt = 0;
        m_ptr = 0;
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        int         run;
        int         hits;
        do_reset(4'b1111);
        step(4'b1111);
        check("rst_release_grant", int'(grant), 1);
        for (int v = 0; v < 16; v++) begin
            r = {v[0], v[1], v[2], v[3]};
            step(r);
        end
        step(4'b0000);
        check("sweep_idle_busy", int'(busy), 0);
        do_reset(4'b0000);
        step(4'b1111);
        for (int k = 0; k < 4; k++) begin
            r = 4'b1111 & ~grant;
            step(r);
            check("rotation", int'(grant), 1 << ((k + 1) % 4));
            step(4'b1111);
        end
        do_reset(4'b0000);
        hits = 0;
        for (int k = 0; k < 9; k++) begin
            step(4'b0011);
            if (grant == 4'b0001) hits++;
        end
        check("hold_limit_cycles", hits, 8);
        check("hold_limit_handover", int'(grant), 2);
        do_reset(4'b0000);
        for (int k = 0; k < 20; k++) step(4'b0100);
        check("lone_owner_grant", int'(grant), 4);
        check("lone_owner_cnt", int'(dut.hold_cnt), HOLD_MAX);
        do_reset(4'b0000);
        step(4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_grant", int'(grant), 0);
        check("async_reset_busy", int'(busy), 0);
        do_reset(4'b0010);
        step(4'b0010);
        check("post_reset_grant", int'(grant), 2);
        check("post_reset_ptr", int'(dut.ptr), 2);
        for (int n = 0; n < 150; n++) begin
            r = 4'($urandom_range(0, 15));
            run = $urandom_range(1, 12);
            for (int k = 0; k < run; k++) step(r);
            if ($urandom_range(0, 39) == 0) do_reset(4'($urandom_range(0, 15)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
